// File: rtl/fp_add_sub_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor with a valid/ready handshake, a tag and exception flags.
// Define FP_FTZ_EN to treat subnormal inputs as zero and flush subnormal results to signed zero.
module fp_add_sub_pipe #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_is_sub,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_res,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             out_flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 4;                       // hidden + fraction + guard/round/sticky
  localparam int LZW = $clog2(MW + 1);
  localparam int XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- Stage 1: unpack, classify, swap, align ----------------
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp, a_eexp, b_eexp, big_exp, small_exp, exp_diff;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic [MAN_W:0]   a_mant, b_mant, big_mant, small_mant;
  logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_ge_b, big_sign;
  logic [2*MW-1:0]  shifted;
  logic [MW-1:0]    small_al;
  logic [W-1:0]     spec_res;
  logic             spec_nv, is_special;

  assign a_sign = in_a[W-1];
  assign a_exp  = in_a[W-2:MAN_W];
  assign a_frac = in_a[MAN_W-1:0];
  assign b_sign = in_b[W-1] ^ in_is_sub;
  assign b_exp  = in_b[W-2:MAN_W];
  assign b_frac = in_b[MAN_W-1:0];

  assign a_nan  = (a_exp == EXP_MAX) & (|a_frac);
  assign b_nan  = (b_exp == EXP_MAX) & (|b_frac);
  assign a_snan = a_nan & ~a_frac[MAN_W-1];
  assign b_snan = b_nan & ~b_frac[MAN_W-1];
  assign a_inf  = (a_exp == EXP_MAX) & ~(|a_frac);
  assign b_inf  = (b_exp == EXP_MAX) & ~(|b_frac);
  assign is_special = a_nan | b_nan | a_inf | b_inf;

`ifdef FP_FTZ_EN
  assign a_mant = (|a_exp) ? {1'b1, a_frac} : '0;
  assign b_mant = (|b_exp) ? {1'b1, b_frac} : '0;
`else
  assign a_mant = {|a_exp, a_frac};
  assign b_mant = {|b_exp, b_frac};
`endif
  // Subnormals share the scale of exponent 1; only the hidden bit differs.
  assign a_eexp = (|a_exp) ? a_exp : EXP_W'(1);
  assign b_eexp = (|b_exp) ? b_exp : EXP_W'(1);

  assign a_ge_b     = {a_eexp, a_mant} >= {b_eexp, b_mant};
  assign big_sign   = a_ge_b ? a_sign : b_sign;
  assign big_exp    = a_ge_b ? a_eexp : b_eexp;
  assign small_exp  = a_ge_b ? b_eexp : a_eexp;
  assign big_mant   = a_ge_b ? a_mant : b_mant;
  assign small_mant = a_ge_b ? b_mant : a_mant;
  assign exp_diff   = big_exp - small_exp;

  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch can be inferred.
  always_comb begin
    shifted = {small_mant, 3'b000, {MW{1'b0}}} >> exp_diff;
    if (32'(exp_diff) >= MAN_W + 3)
      small_al = {{(MW-1){1'b0}}, |small_mant};
    else
      small_al = {shifted[2*MW-1:MW+1], shifted[MW] | (|shifted[MW-1:0])};
  end

  always_comb begin
    spec_res = QNAN;
    spec_nv  = a_snan | b_snan;
    if (!(a_nan || b_nan)) begin
      if (a_inf && b_inf && (a_sign != b_sign)) spec_nv = 1'b1;
      else if (a_inf) spec_res = {a_sign, EXP_MAX, {MAN_W{1'b0}}};
      else            spec_res = {b_sign, EXP_MAX, {MAN_W{1'b0}}};
    end
  end

  logic             s1_valid, s1_special, s1_nv, s1_sign, s1_sub;
  logic [TAG_W-1:0] s1_tag;
  logic [W-1:0]     s1_spec;
  logic [EXP_W-1:0] s1_exp;
  logic [MW-1:0]    s1_big, s1_small;

  // ---------------- Stage 2: add/sub, leading-zero count, normalise ----------------
  logic [MW:0]      sum;
  logic [LZW-1:0]   lz;
  logic [XW-1:0]    exp_x, lz_x, sh, n_exp;
  logic [MW-1:0]    n_mant;
  logic             n_zero, n_sign;

  always_comb begin
    sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small}) : ({1'b0, s1_big} + {1'b0, s1_small});
    lz  = LZW'(MW);
    for (int i = 0; i < MW; i++)
      if (sum[i]) lz = LZW'(MW - 1 - i);
    exp_x  = {{(XW-EXP_W){1'b0}}, s1_exp};
    lz_x   = {{(XW-LZW){1'b0}}, lz};
    sh     = '0;
    n_zero = ~(|sum);
    // Exact cancellation is +0; equal-signed zeros keep their sign.
    n_sign = n_zero ? (s1_sign & ~s1_sub) : s1_sign;
    if (sum[MW]) begin
      n_mant = {sum[MW:2], sum[1] | sum[0]};
      n_exp  = exp_x + XW'(1);
    end else begin
      // Left shift stops at exponent 1, leaving subnormal results denormalised.
      sh     = (lz_x < exp_x - XW'(1)) ? lz_x : exp_x - XW'(1);
      n_mant = sum[MW-1:0] << sh;
      n_exp  = exp_x - sh;
    end
  end

  logic             s2_valid, s2_special, s2_nv, s2_sign, s2_zero;
  logic [TAG_W-1:0] s2_tag;
  logic [W-1:0]     s2_spec;
  logic [XW-1:0]    s2_exp;
  logic [MW-1:0]    s2_mant;

  // ---------------- Stage 3: round to nearest even, pack, flags ----------------
  logic             inexact, round_up, ovf, tiny;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W:0]   mant_f;
  logic [XW-1:0]    exp_r;
  logic [EXP_W-1:0] exp_field;
  logic [W-1:0]     p_res;
  logic [3:0]       p_flags;

  always_comb begin
    inexact  = s2_mant[2] | (|s2_mant[1:0]);
    round_up = s2_mant[2] & ((|s2_mant[1:0]) | s2_mant[3]);
    mant_r   = {1'b0, s2_mant[MW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    if (mant_r[MAN_W+1]) begin
      mant_f = mant_r[MAN_W+1:1];
      exp_r  = s2_exp + XW'(1);
    end else begin
      mant_f = mant_r[MAN_W:0];
      exp_r  = s2_exp;
    end
    tiny      = ~mant_f[MAN_W];
    exp_field = tiny ? '0 : exp_r[EXP_W-1:0];
    ovf       = exp_r >= {{(XW-EXP_W){1'b0}}, EXP_MAX};
    p_res     = {s2_sign, exp_field, mant_f[MAN_W-1:0]};
    p_flags   = {2'b00, tiny & inexact, inexact};
    if (s2_special) begin
      p_res   = s2_spec;
      p_flags = {s2_nv, 3'b000};
    end else if (s2_zero) begin
      p_res   = {s2_sign, {(W-1){1'b0}}};
      p_flags = 4'b0000;
    end else if (ovf) begin
      p_res   = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
      p_flags = 4'b0101;
    end
`ifdef FP_FTZ_EN
    else if (tiny) begin
      p_res   = {s2_sign, {(W-1){1'b0}}};
      p_flags = 4'b0011;
    end
`endif
  end

  // ---------------- Registers ----------------
  // NOTE: sequential state uses non-blocking '<=' so every stage samples the previous stage's old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_res   <= p_res;
        out_tag   <= s2_tag;
        out_flags <= p_flags;
      end
    end
  end

  // NOTE: datapath registers carry no reset; a slot's contents are ignored unless its valid bit is set.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_tag     <= in_tag;
      s1_special <= is_special;
      s1_spec    <= spec_res;
      s1_nv      <= spec_nv;
      s1_sign    <= big_sign;
      s1_sub     <= a_sign ^ b_sign;
      s1_exp     <= big_exp;
      s1_big     <= {big_mant, 3'b000};
      s1_small   <= small_al;

      s2_tag     <= s1_tag;
      s2_special <= s1_special;
      s2_spec    <= s1_spec;
      s2_nv      <= s1_nv;
      s2_sign    <= n_sign;
      s2_zero    <= n_zero;
      s2_exp     <= n_exp;
      s2_mant    <= n_mant;
    end
  end

endmodule
